// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - shared state encoding, default tuning constants and hp helper for combat_arbiter
package combat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIGHT = 2'd1,
    ST_KO    = 2'd2
  } fight_state_t;

  localparam int HP_MAX_DEF         = 100;
  localparam int PUNCH_DMG_DEF      = 10;
  localparam int BLOCK_DMG_DEF      = 2;
  localparam int HITSTUN_FRAMES_DEF = 12;
  localparam int COOLDOWN_FRAMES_DEF = 20;

  // Health never wraps: damage larger than what is left pins the bar at zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/fighter_timer.sv
// rtl/fighter_timer.sv - per-player stun and cooldown frame counters
module fighter_timer #(
  parameter int HITSTUN_FRAMES  = 12,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic stun_load_i,
  input  logic cd_load_i,
  output logic stunned_o,
  output logic cd_busy_o
);

  localparam logic [7:0] STUN_LEN = 8'(HITSTUN_FRAMES);
  localparam logic [7:0] CD_LEN   = 8'(COOLDOWN_FRAMES);

  logic [7:0] stun_q, stun_d;
  logic [7:0] cd_q, cd_d;

  // A reload wins over the per-frame decrement; clear wins over everything.
  always_comb begin
    stun_d = stun_q;
    if (clear_i) begin
      stun_d = 8'd0;
    end else if (stun_load_i) begin
      stun_d = STUN_LEN;
    end else if (stun_q != 8'd0) begin
      stun_d = stun_q - 8'd1;
    end
  end

  always_comb begin
    cd_d = cd_q;
    if (clear_i) begin
      cd_d = 8'd0;
    end else if (cd_load_i) begin
      cd_d = CD_LEN;
    end else if (cd_q != 8'd0) begin
      cd_d = cd_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stun_q <= 8'd0;
      cd_q   <= 8'd0;
    end else begin
      stun_q <= stun_d;
      cd_q   <= cd_d;
    end
  end

  assign stunned_o = (stun_q != 8'd0);
  assign cd_busy_o = (cd_q != 8'd0);

endmodule

// File: rtl/combat_arbiter.sv
// rtl/combat_arbiter.sv - two-player hit arbitration, health, stun, knockback and round FSM; COMBAT_COMBO_SCALING_EN halves follow-up hits on stunned defenders
module combat_arbiter
  import combat_pkg::*;
#(
  parameter int HP_MAX          = HP_MAX_DEF,
  parameter int PUNCH_DMG       = PUNCH_DMG_DEF,
  parameter int BLOCK_DMG       = BLOCK_DMG_DEF,
  parameter int HITSTUN_FRAMES  = HITSTUN_FRAMES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       round_start,
  input  logic       hit_req_p1,
  input  logic       hit_req_p2,
  input  logic       block_p1,
  input  logic       block_p2,
  output logic [7:0] hp_p1,
  output logic [7:0] hp_p2,
  output logic       stun_p1,
  output logic       stun_p2,
  output logic       kb_p1,
  output logic       kb_p2,
  output logic       ko_p1,
  output logic       ko_p2,
  output logic [1:0] fight_state
);

  localparam logic [7:0] HP_FULL = 8'(HP_MAX);
  localparam logic [7:0] PUNCH   = 8'(PUNCH_DMG);
  localparam logic [7:0] CHIP    = 8'(BLOCK_DMG);

  // Reset asserts asynchronously but releases two frames later.
  logic [1:0] rst_sync_q;
  logic       core_rst_n;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync_q[1];

  fight_state_t state_q, state_d;
  logic [7:0]   hp1_q, hp1_d, hp2_q, hp2_d;
  logic         kb1_q, kb1_d, kb2_q, kb2_d;
  logic         ko1_q, ko1_d, ko2_q, ko2_d;

  logic       stunned1, stunned2, cd_busy1, cd_busy2;
  logic       enter_fight, acc1, acc2;
  logic [7:0] dmg_to_p1, dmg_to_p2;
  logic       stun_load1, stun_load2;

  assign enter_fight = round_start && (state_q != ST_FIGHT);
  assign acc1 = (state_q == ST_FIGHT) && hit_req_p1 && !stunned1 && !cd_busy1;
  assign acc2 = (state_q == ST_FIGHT) && hit_req_p2 && !stunned2 && !cd_busy2;

`ifdef COMBAT_COMBO_SCALING_EN
  localparam logic [7:0] COMBO_DMG = ((PUNCH_DMG / 2) == 0) ? 8'd1 : 8'(PUNCH_DMG / 2);

  assign dmg_to_p1  = block_p1 ? CHIP : (stunned1 ? COMBO_DMG : PUNCH);
  assign dmg_to_p2  = block_p2 ? CHIP : (stunned2 ? COMBO_DMG : PUNCH);
  assign stun_load1 = acc2 && !block_p1 && !stunned1;
  assign stun_load2 = acc1 && !block_p2 && !stunned2;
`else
  assign dmg_to_p1  = block_p1 ? CHIP : PUNCH;
  assign dmg_to_p2  = block_p2 ? CHIP : PUNCH;
  assign stun_load1 = acc2 && !block_p1;
  assign stun_load2 = acc1 && !block_p2;
`endif

  fighter_timer #(
    .HITSTUN_FRAMES (HITSTUN_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_timer_p1 (
    .clk_i      (frame_clk),
    .rst_ni     (core_rst_n),
    .clear_i    (enter_fight),
    .stun_load_i(stun_load1),
    .cd_load_i  (acc1),
    .stunned_o  (stunned1),
    .cd_busy_o  (cd_busy1)
  );

  fighter_timer #(
    .HITSTUN_FRAMES (HITSTUN_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_timer_p2 (
    .clk_i      (frame_clk),
    .rst_ni     (core_rst_n),
    .clear_i    (enter_fight),
    .stun_load_i(stun_load2),
    .cd_load_i  (acc2),
    .stunned_o  (stunned2),
    .cd_busy_o  (cd_busy2)
  );

  always_comb begin
    state_d = state_q;
    hp1_d   = hp1_q;
    hp2_d   = hp2_q;
    ko1_d   = ko1_q;
    ko2_d   = ko2_q;
    kb1_d   = 1'b0;
    kb2_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_KO: begin
        if (round_start) begin
          state_d = ST_FIGHT;
          hp1_d   = HP_FULL;
          hp2_d   = HP_FULL;
          ko1_d   = 1'b0;
          ko2_d   = 1'b0;
        end
      end
      ST_FIGHT: begin
        // Each side is judged on pre-edge state, so a trade lands both hits.
        if (acc2) hp1_d = sat_sub(hp1_q, dmg_to_p1);
        if (acc1) hp2_d = sat_sub(hp2_q, dmg_to_p2);
        kb1_d = acc2 && !block_p1;
        kb2_d = acc1 && !block_p2;
        ko1_d = (hp1_d == 8'd0);
        ko2_d = (hp2_d == 8'd0);
        if (ko1_d || ko2_d) state_d = ST_KO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= ST_IDLE;
      hp1_q   <= HP_FULL;
      hp2_q   <= HP_FULL;
      kb1_q   <= 1'b0;
      kb2_q   <= 1'b0;
      ko1_q   <= 1'b0;
      ko2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp1_q   <= hp1_d;
      hp2_q   <= hp2_d;
      kb1_q   <= kb1_d;
      kb2_q   <= kb2_d;
      ko1_q   <= ko1_d;
      ko2_q   <= ko2_d;
    end
  end

  assign hp_p1       = hp1_q;
  assign hp_p2       = hp2_q;
  assign stun_p1     = stunned1;
  assign stun_p2     = stunned2;
  assign kb_p1       = kb1_q;
  assign kb_p2       = kb2_q;
  assign ko_p1       = ko1_q;
  assign ko_p2       = ko2_q;
  assign fight_state = state_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// tb/tb_combat_arbiter.sv - directed scoreboard bench for combat_arbiter (default and short-round instances)
module tb_combat_arbiter;

`ifdef COMBAT_COMBO_SCALING_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic round_start = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, b1 = 1'b0, b2 = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] a_hp1, a_hp2, b_hp1, b_hp2;
  logic       a_s1, a_s2, a_k1, a_k2, a_o1, a_o2;
  logic       b_s1, b_s2, b_k1, b_k2, b_o1, b_o2;
  logic [1:0] a_st, b_st;

  combat_arbiter dut_a (
    .frame_clk(clk), .Reset_n(rst_n), .round_start(round_start),
    .hit_req_p1(h1), .hit_req_p2(h2), .block_p1(b1), .block_p2(b2),
    .hp_p1(a_hp1), .hp_p2(a_hp2), .stun_p1(a_s1), .stun_p2(a_s2),
    .kb_p1(a_k1), .kb_p2(a_k2), .ko_p1(a_o1), .ko_p2(a_o2), .fight_state(a_st)
  );

  // Short round with fast cooldown so trades and follow-up hits on a stunned defender are reachable.
  combat_arbiter #(.HP_MAX(25), .COOLDOWN_FRAMES(4)) dut_b (
    .frame_clk(clk), .Reset_n(rst_n), .round_start(round_start),
    .hit_req_p1(h1), .hit_req_p2(h2), .block_p1(b1), .block_p2(b2),
    .hp_p1(b_hp1), .hp_p2(b_hp2), .stun_p1(b_s1), .stun_p2(b_s2),
    .kb_p1(b_k1), .kb_p2(b_k2), .ko_p1(b_o1), .ko_p2(b_o2), .fight_state(b_st)
  );

  wire [23:0] obs_a = {a_st, a_hp1, a_hp2, a_s1, a_s2, a_k1, a_k2, a_o1, a_o2};
  wire [23:0] obs_b = {b_st, b_hp1, b_hp2, b_s1, b_s2, b_k1, b_k2, b_o1, b_o2};

  typedef struct {
    string       tag;
    bit          sel;
    logic [23:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [23:0] pk(input logic [1:0] st, input logic [7:0] hp1, input logic [7:0] hp2,
                                     input logic s1, input logic s2, input logic k1, input logic k2,
                                     input logic o1, input logic o2);
    return {st, hp1, hp2, s1, s2, k1, k2, o1, o2};
  endfunction

  task automatic push_exp(input string tag, input bit sel, input logic [23:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t e;
    logic [23:0] obs;
    e = sb.pop_front();
    obs = e.sel ? obs_b : obs_a;
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) check_now();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk();
    tick();
    drain();
  endtask

  initial begin
    logic [7:0] hp_combo;
    hp_combo = COMBO ? 8'd10 : 8'd5;

    repeat (3) tick();
    push_exp("reset_a", 0, pk(2'd0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0));
    push_exp("reset_b", 1, pk(2'd0, 8'd25, 8'd25, 0, 0, 0, 0, 0, 0));
    drain();

    rst_n = 1'b1;
    round_start = 1'b1;
    push_exp("sync_edge1", 0, pk(2'd0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0));
    tick_chk();
    push_exp("sync_edge2", 0, pk(2'd0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0));
    tick_chk();
    push_exp("round_start", 0, pk(2'd1, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0));
    tick_chk();
    round_start = 1'b0;

    h1 = 1'b1;
    push_exp("p1_hit", 0, pk(2'd1, 8'd100, 8'd90, 0, 1, 0, 1, 0, 0));
    tick_chk();
    for (int k = 1; k <= 20; k++) begin
      push_exp("p1_cooldown", 0, pk(2'd1, 8'd100, 8'd90, 0, (k < 12), 0, 0, 0, 0));
      tick_chk();
    end
    push_exp("p1_rehit", 0, pk(2'd1, 8'd100, 8'd80, 0, 1, 0, 1, 0, 0));
    tick_chk();
    h1 = 1'b0;
    repeat (13) tick();

    h2 = 1'b1;
    b1 = 1'b1;
    push_exp("p2_blocked", 0, pk(2'd1, 8'd98, 8'd80, 0, 0, 0, 0, 0, 0));
    tick_chk();
    h2 = 1'b0;
    b1 = 1'b0;
    repeat (21) tick();

    h1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      push_exp("p1_chain", 0, pk(2'd1, 8'd98, 8'(70 - 10 * n), 0, 1, 0, 1, 0, 0));
      tick_chk();
      if (n < 3) repeat (20) tick();
    end
    h1 = 1'b0;

    rst_n = 1'b0;
    #1;
    push_exp("async_reset_a", 0, pk(2'd0, 8'd100, 8'd100, 0, 0, 0, 0, 0, 0));
    push_exp("async_reset_b", 1, pk(2'd0, 8'd25, 8'd25, 0, 0, 0, 0, 0, 0));
    drain();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    round_start = 1'b1;
    push_exp("b_round_start", 1, pk(2'd1, 8'd25, 8'd25, 0, 0, 0, 0, 0, 0));
    tick_chk();
    round_start = 1'b0;

    h1 = 1'b1;
    h2 = 1'b1;
    push_exp("trade1", 1, pk(2'd1, 8'd15, 8'd15, 1, 1, 1, 1, 0, 0));
    tick_chk();
    repeat (12) tick();
    push_exp("trade2", 1, pk(2'd1, 8'd5, 8'd5, 1, 1, 1, 1, 0, 0));
    tick_chk();
    repeat (12) tick();
    push_exp("double_ko", 1, pk(2'd2, 8'd0, 8'd0, 1, 1, 1, 1, 1, 1));
    tick_chk();
    push_exp("ko_hold", 1, pk(2'd2, 8'd0, 8'd0, 1, 1, 0, 0, 1, 1));
    tick_chk();
    repeat (12) tick();
    push_exp("ko_ignore", 1, pk(2'd2, 8'd0, 8'd0, 0, 0, 0, 0, 1, 1));
    tick_chk();
    h1 = 1'b0;
    h2 = 1'b0;

    round_start = 1'b1;
    push_exp("ko_restart", 1, pk(2'd1, 8'd25, 8'd25, 0, 0, 0, 0, 0, 0));
    tick_chk();
    round_start = 1'b0;

    h1 = 1'b1;
    push_exp("combo_first", 1, pk(2'd1, 8'd25, 8'd15, 0, 1, 0, 1, 0, 0));
    tick_chk();
    for (int k = 1; k <= 4; k++) begin
      push_exp("combo_cooldown", 1, pk(2'd1, 8'd25, 8'd15, 0, 1, 0, 0, 0, 0));
      tick_chk();
    end
    push_exp("combo_second", 1, pk(2'd1, 8'd25, hp_combo, 0, 1, 0, 1, 0, 0));
    tick_chk();
    h1 = 1'b0;
    repeat (6) tick();
    push_exp("combo_stun", 1, pk(2'd1, 8'd25, hp_combo, 0, !COMBO, 0, 0, 0, 0));
    tick_chk();

    round_start = 1'b1;
    push_exp("start_in_fight", 1, pk(2'd1, 8'd25, hp_combo, 0, !COMBO, 0, 0, 0, 0));
    tick_chk();
    round_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
